acc_store_unit: RTL and testbench
=================================

# acc_store_unit

Write-back engine for the unioperand datapath. On a store command it captures the 16-bit accumulator value and writes it to the byte-wide data memory as two little-endian byte writes over a req/ack handshake. It reports completion with `done`, or a bus timeout with `err`. It is the read-out counterpart of the accumulator load path: the accumulator is loaded from the datapath, and this block drains it to memory.

## Interface
- `ADDR_W`, default 8: data-memory address width.
- `TIMEOUT`, default 15: maximum number of `mem_req` cycles without `mem_ack` per beat before abort (1..255).
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `store`  in  1: store command; sampled only in IDLE.
- `st_addr`  in  ADDR_W: byte address for the low byte.
- `acc_in`  in  16: accumulator output.
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle pulse when both bytes have been written.
- `err`  out  1: one-cycle pulse on a timeout abort.
- `mem_req`  out  1: memory write request.
- `mem_addr`  out  ADDR_W: write address.
- `mem_wdata`  out  8: write data.
- `mem_ack`  in  1: memory accepted the current beat.

## Operation
- States: IDLE, LO, HI.
- IDLE:
  - When `store`=1 is sampled, register `acc_in` into data_q, register `st_addr` into addr_q, clear the wait counter, and go to LO.
  - Otherwise stay in IDLE.
- LO:
  - Drive `mem_req`=1, `mem_addr`=addr_q, `mem_wdata`=data_q[7:0].
  - When `mem_ack`=1 is sampled, clear the counter and go to HI.
- HI:
  - Drive `mem_req`=1, `mem_addr`=addr_q+1 (wraps modulo 2^ADDR_W, so 0xFF+1 = 0x00), `mem_wdata`=data_q[15:8].
  - When `mem_ack`=1 is sampled, pulse `done` in the next cycle and go to IDLE.
- Wait counter (8 bits):
  - Increments each LO/HI cycle in which `mem_ack`=0.
  - If it reaches TIMEOUT, abort: drop `mem_req`, go to IDLE, and pulse `err` next cycle. `done` does not pulse.
  - If `mem_ack`=1 arrives in the same cycle the counter would reach TIMEOUT, the ack wins.
- `mem_addr` and `mem_wdata` are stable for every cycle `mem_req` is high within a beat. `acc_in` changes after capture are ignored.
- In IDLE, `mem_addr` and `mem_wdata` hold 0.
- A `store` received while busy is dropped; there is no queue.
- A `store` in the cycle `done` or `err` is high is accepted, because the FSM is already back in IDLE.
- `mem_ack` in IDLE is ignored.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `err`, and `mem_req` all 0; `mem_addr`=0; `mem_wdata`=0; data_q=0; addr_q=0; counter=0.
- All outputs are registered or decoded from the state; there is no combinational path from `mem_ack` to any output.
- `store` sampled at edge k:
  - `busy` and `mem_req` are high from cycle k+1.
  - Zero-wait case (ack in the same cycle as the request): the LO beat is in cycle k+1, the HI beat in k+2, and `done`=1 in k+3 with `busy`=0 in that same cycle.
  - Minimum command-to-done latency is 3 cycles.
- Each wait cycle per beat adds 1 cycle.
- A timeout abort occurs after TIMEOUT unacked cycles of a beat; `err` pulses the cycle after the abort.
- `mem_req` stays high continuously across the LO→HI transition, and address/data switch on that edge.
- Asserting `rst` mid-transfer immediately forces all outputs to their reset values. The partial write is abandoned, and no `done` or `err` is produced.

## Test plan
- Zero-wait store: `acc_in`=0xA55A, `st_addr`=0x10, `mem_ack` tied to 1 → beat 0x10/0x5A, then 0x11/0xA5; `done` high exactly 3 cycles after `store`; `err` never high.
- Wait states and capture: `acc_in`=0x1234, ack delayed 2 cycles per beat; change `acc_in` to 0xFFFF after capture → data 0x34 then 0x12, each stable while `mem_req`=1; `done` at cycle 7.
- Address wrap: `st_addr`=0xFF, `acc_in`=0xBEEF → writes 0xFF/0xEF and 0x00/0xBE.
- Timeout: TIMEOUT=15, ack never asserted → `mem_req` high for 15 cycles in LO, then low; `err` pulses once; `done` stays 0; `busy` returns to 0. Ack on the 15th cycle → no error, HI beat proceeds.
- Command overlap: `store` while busy is ignored (only one transfer occurs); `store` during the `done` pulse starts a new transfer with `mem_req` high on the next cycle.
- Reset mid-operation: `rst`=0 during the HI beat → `mem_req`, `busy`, `mem_addr`, and `mem_wdata` go to 0 immediately; no `done`; after release, a new store completes normally.

Source files
------------

// File: rtl/acc_store_unit_if.sv
// acc_store_unit_if: byte-wide memory write bus with req/ack handshake
interface acc_store_unit_if #(parameter int ADDR_W = 8);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_ack;
   modport master (output mem_req, mem_addr, mem_wdata, input mem_ack);
   modport slave  (input mem_req, mem_addr, mem_wdata, output mem_ack);
endinterface

// File: rtl/acc_store_unit.sv
// acc_store_unit: drains the 16-bit accumulator to byte memory as two little-endian writes
module acc_store_unit #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               store,
   input  logic [ADDR_W-1:0]  st_addr,
   input  logic [15:0]        acc_in,
   output logic               busy,
   output logic               done,
   output logic               err,
   acc_store_unit_if.master   mem
);
   typedef enum logic [1:0] {IDLE, LO, HI} state_t;
   state_t            state_q, state_d;
   logic [15:0]       data_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        cnt_q, cnt_d, cnt_inc;
   logic              done_d, err_d;
   assign cnt_inc = cnt_q + 8'd1;
   // next state: ack always beats a timeout landing in the same cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (store) begin
               state_d = LO;
               cnt_d   = '0;
            end
         end
         LO, HI: begin
            if (mem.mem_ack) begin
               state_d = (state_q == LO) ? HI : IDLE;
               cnt_d   = '0;
               done_d  = (state_q == HI);
            end else if (cnt_inc == 8'(TIMEOUT)) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state, wait counter and completion pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done    <= done_d;
         err     <= err_d;
      end
   end
   // capture operands once per command so later acc_in changes are ignored
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
         addr_q <= '0;
      end else if (state_q == IDLE && store) begin
         data_q <= acc_in;
         addr_q <= st_addr;
      end
   end
   // bus outputs decoded from state so they carry no path from mem_ack
   always_comb begin
      busy          = (state_q != IDLE);
      mem.mem_req   = busy;
      mem.mem_addr  = (state_q == LO) ? addr_q : (state_q == HI) ? addr_q + 1'b1 : '0;
      mem.mem_wdata = (state_q == LO) ? data_q[7:0] : (state_q == HI) ? data_q[15:8] : 8'h00;
   end
endmodule

// File: tb/tb_acc_store_unit.sv
// tb_acc_store_unit: randomized and directed checks of acc_store_unit against a timing model
module tb_acc_store_unit;
   localparam int TO = 15;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        store = 1'b0;
   logic [7:0]  st_addr = '0;
   logic [15:0] acc_in = '0;
   logic        busy, done, err;
   int          checks = 0;
   int          failures = 0;
   acc_store_unit_if #(.ADDR_W(8)) bus ();
   acc_store_unit #(.ADDR_W(8), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .store(store), .st_addr(st_addr), .acc_in(acc_in),
      .busy(busy), .done(done), .err(err), .mem(bus)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // expected timing from the handshake rules: cycles counted from the store edge
   function automatic void model(input int w0, input int w1, output int dcyc, output int ecyc,
                                 output int rq, output int nb);
      if (w0 >= TO) begin
         dcyc = -1; ecyc = TO + 1; rq = TO; nb = 0;
      end else if (w1 >= TO) begin
         dcyc = -1; ecyc = w0 + 1 + TO + 1; rq = w0 + 1 + TO; nb = 1;
      end else begin
         dcyc = w0 + w1 + 3; ecyc = -1; rq = w0 + w1 + 2; nb = 2;
      end
   endfunction
   // drives one store and a memory responder that waits w0/w1 cycles per beat; records observations
   task automatic run_xfer(input logic [7:0] a, input logic [15:0] d, input int w0, input int w1,
                           input int drop_cyc, output int dcyc, output int ecyc, output int rq,
                           output int nb, output int dn, output int en, output logic [15:0] oa,
                           output logic [15:0] od, output logic stable, output logic busy_end);
      int w[2];
      int wc, fin;
      logic [7:0] fa, fd;
      w[0] = w0; w[1] = w1;
      dcyc = -1; ecyc = -1; rq = 0; nb = 0; dn = 0; en = 0; oa = '0; od = '0;
      stable = 1'b1; busy_end = 1'b1; wc = 0; fin = -1; fa = '0; fd = '0;
      store = 1'b1; st_addr = a; acc_in = d; bus.mem_ack = 1'b0;
      tick;
      store = 1'b0;
      acc_in = 16'($urandom);
      for (int cyc = 1; cyc <= 80; cyc++) begin
         store = (cyc == drop_cyc);
         st_addr = ~a;
         if (done) begin dn++; if (dcyc < 0) dcyc = cyc; end
         if (err) begin en++; if (ecyc < 0) ecyc = cyc; end
         bus.mem_ack = 1'b0;
         if (bus.mem_req) begin
            rq++;
            if (wc == 0) begin
               fa = bus.mem_addr; fd = bus.mem_wdata;
            end else if (bus.mem_addr !== fa || bus.mem_wdata !== fd) begin
               stable = 1'b0;
            end
            if (nb < 2 && wc == w[nb]) begin
               bus.mem_ack = 1'b1;
               oa[8*nb +: 8] = bus.mem_addr;
               od[8*nb +: 8] = bus.mem_wdata;
               nb++;
               wc = 0;
            end else begin
               wc++;
            end
         end
         if ((done || err) && fin < 0) fin = cyc;
         if (fin >= 0 && cyc >= fin + 2) begin
            busy_end = busy;
            break;
         end
         tick;
      end
      bus.mem_ack = 1'b0;
      store = 1'b0;
   endtask
   task automatic test_reset;
      bus.mem_ack = 1'b0;
      #2;
      checks++;
      if ({busy, done, err, bus.mem_req, bus.mem_addr, bus.mem_wdata} !== 20'h0) begin
         failures++;
         $display("FAIL reset_values: got busy=%b done=%b err=%b req=%b addr=%h wdata=%h, want all 0",
                  busy, done, err, bus.mem_req, bus.mem_addr, bus.mem_wdata);
      end
      #10 rst = 1'b1;
      tick;
      bus.mem_ack = 1'b1;
      repeat (3) tick;
      checks++;
      if ({busy, bus.mem_req, done, err} !== 4'b0) begin
         failures++;
         $display("FAIL idle_ack_ignored: got busy=%b req=%b done=%b err=%b, want 0000",
                  busy, bus.mem_req, done, err);
      end
      bus.mem_ack = 1'b0;
      tick;
   endtask
   task automatic test_zero_wait;
      int dcyc, ecyc, rq, nb, dn, en;
      logic [15:0] oa, od;
      logic stable, be;
      run_xfer(8'h10, 16'hA55A, 0, 0, -1, dcyc, ecyc, rq, nb, dn, en, oa, od, stable, be);
      checks++;
      if (nb !== 2 || oa !== 16'h1110 || od !== 16'hA55A) begin
         failures++;
         $display("FAIL zero_wait_beats: got nb=%0d addr=%h data=%h, want 2 1110 A55A", nb, oa, od);
      end
      checks++;
      if (dcyc !== 3 || dn !== 1) begin
         failures++;
         $display("FAIL zero_wait_done: got cycle=%0d pulses=%0d, want 3 1", dcyc, dn);
      end
      checks++;
      if (en !== 0 || be !== 1'b0) begin
         failures++;
         $display("FAIL zero_wait_err_busy: got err_pulses=%0d busy=%b, want 0 0", en, be);
      end
      checks++;
      if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin
         failures++;
         $display("FAIL idle_bus_zero: got addr=%h wdata=%h, want 00 00", bus.mem_addr, bus.mem_wdata);
      end
   endtask
   task automatic test_wait_capture;
      int dcyc, ecyc, rq, nb, dn, en;
      logic [15:0] oa, od;
      logic stable, be;
      run_xfer(8'h20, 16'h1234, 2, 2, -1, dcyc, ecyc, rq, nb, dn, en, oa, od, stable, be);
      checks++;
      if (od !== 16'h1234 || oa !== 16'h2120) begin
         failures++;
         $display("FAIL wait_capture_data: got addr=%h data=%h, want 2120 1234", oa, od);
      end
      checks++;
      if (dcyc !== 7 || rq !== 6 || stable !== 1'b1) begin
         failures++;
         $display("FAIL wait_timing: got done=%0d req_cycles=%0d stable=%b, want 7 6 1", dcyc, rq, stable);
      end
   endtask
   task automatic test_wrap;
      int dcyc, ecyc, rq, nb, dn, en;
      logic [15:0] oa, od;
      logic stable, be;
      run_xfer(8'hFF, 16'hBEEF, 1, 0, -1, dcyc, ecyc, rq, nb, dn, en, oa, od, stable, be);
      checks++;
      if (oa !== 16'h00FF || od !== 16'hBEEF || dcyc !== 4) begin
         failures++;
         $display("FAIL addr_wrap: got addr=%h data=%h done=%0d, want 00FF BEEF 4", oa, od, dcyc);
      end
   endtask
   task automatic test_timeout;
      int dcyc, ecyc, rq, nb, dn, en;
      logic [15:0] oa, od;
      logic stable, be;
      run_xfer(8'h30, 16'h5566, 255, 0, -1, dcyc, ecyc, rq, nb, dn, en, oa, od, stable, be);
      checks++;
      if (rq !== TO || nb !== 0) begin
         failures++;
         $display("FAIL timeout_req_cycles: got req=%0d beats=%0d, want %0d 0", rq, nb, TO);
      end
      checks++;
      if (ecyc !== TO + 1 || en !== 1 || dn !== 0 || be !== 1'b0) begin
         failures++;
         $display("FAIL timeout_err: got err_cycle=%0d err=%0d done=%0d busy=%b, want %0d 1 0 0",
                  ecyc, en, dn, be, TO + 1);
      end
      run_xfer(8'h31, 16'h7788, TO - 1, 0, -1, dcyc, ecyc, rq, nb, dn, en, oa, od, stable, be);
      checks++;
      if (en !== 0 || dcyc !== TO + 2 || od !== 16'h7788) begin
         failures++;
         $display("FAIL ack_beats_timeout: got err=%0d done=%0d data=%h, want 0 %0d 7788", en, dcyc, od, TO + 2);
      end
      run_xfer(8'h32, 16'h99AA, 0, 255, -1, dcyc, ecyc, rq, nb, dn, en, oa, od, stable, be);
      checks++;
      if (nb !== 1 || ecyc !== TO + 2 || dn !== 0 || rq !== TO + 1) begin
         failures++;
         $display("FAIL timeout_hi: got beats=%0d err_cycle=%0d done=%0d req=%0d, want 1 %0d 0 %0d",
                  nb, ecyc, dn, rq, TO + 2, TO + 1);
      end
   endtask
   task automatic test_random;
      int dcyc, ecyc, rq, nb, dn, en, xd, xe, xr, xn, w0, w1;
      logic [15:0] oa, od, d;
      logic [7:0] a, a1;
      logic stable, be, ok;
      for (int i = 0; i < 24; i++) begin
         a = 8'($urandom); d = 16'($urandom);
         w0 = $urandom_range(0, 17); w1 = $urandom_range(0, 17);
         a1 = a + 8'd1;
         model(w0, w1, xd, xe, xr, xn);
         run_xfer(a, d, w0, w1, -1, dcyc, ecyc, rq, nb, dn, en, oa, od, stable, be);
         ok = (nb == xn) && (dcyc == xd) && (ecyc == xe) && (rq == xr) && stable && !be
              && (dn == (xd >= 0 ? 1 : 0)) && (en == (xe >= 0 ? 1 : 0));
         if (xn >= 1) ok = ok && oa[7:0] == a && od[7:0] == d[7:0];
         if (xn == 2) ok = ok && oa[15:8] == a1 && od[15:8] == d[15:8];
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL random_%0d: w=%0d/%0d got beats=%0d done=%0d err=%0d req=%0d addr=%h data=%h stable=%b; want beats=%0d done=%0d err=%0d req=%0d addr=%h%h data=%h",
                     i, w0, w1, nb, dcyc, ecyc, rq, oa, od, stable, xn, xd, xe, xr, a1, a, d);
         end
      end
   endtask
   task automatic test_overlap;
      int dcyc, ecyc, rq, nb, dn, en;
      logic [15:0] oa, od;
      logic stable, be;
      run_xfer(8'h50, 16'hCAFE, 3, 1, 2, dcyc, ecyc, rq, nb, dn, en, oa, od, stable, be);
      checks++;
      if (nb !== 2 || oa !== 16'h5150 || od !== 16'hCAFE || dn !== 1 || be !== 1'b0) begin
         failures++;
         $display("FAIL busy_store_dropped: got beats=%0d addr=%h data=%h done=%0d busy_after=%b, want 2 5150 CAFE 1 0",
                  nb, oa, od, dn, be);
      end
   endtask
   task automatic test_back_to_back;
      int n;
      store = 1'b1; st_addr = 8'h60; acc_in = 16'h0102; bus.mem_ack = 1'b1;
      tick;
      store = 1'b0;
      n = 0;
      while (!done && n < 10) begin tick; n++; end
      checks++;
      if (n !== 2) begin
         failures++;
         $display("FAIL b2b_first_done: got done after %0d extra cycles, want 2", n);
      end
      store = 1'b1; st_addr = 8'h70; acc_in = 16'h0304;
      tick;
      store = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h70 || bus.mem_wdata !== 8'h04) begin
         failures++;
         $display("FAIL b2b_second_start: got req=%b addr=%h wdata=%h, want 1 70 04",
                  bus.mem_req, bus.mem_addr, bus.mem_wdata);
      end
      tick;
      tick;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second_done: got done=%b busy=%b, want 1 0", done, busy);
      end
      bus.mem_ack = 1'b0;
      tick;
   endtask
   task automatic test_reset_mid;
      int dcyc, ecyc, rq, nb, dn, en, pulses;
      logic [15:0] oa, od;
      logic stable, be;
      store = 1'b1; st_addr = 8'h40; acc_in = 16'hC33C;
      tick;
      store = 1'b0; bus.mem_ack = 1'b1;
      tick;
      bus.mem_ack = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h41 || bus.mem_wdata !== 8'hC3) begin
         failures++;
         $display("FAIL mid_hi_beat: got req=%b addr=%h wdata=%h, want 1 41 C3",
                  bus.mem_req, bus.mem_addr, bus.mem_wdata);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({busy, bus.mem_req, bus.mem_addr, bus.mem_wdata} !== 18'h0) begin
         failures++;
         $display("FAIL async_reset: got busy=%b req=%b addr=%h wdata=%h, want all 0",
                  busy, bus.mem_req, bus.mem_addr, bus.mem_wdata);
      end
      pulses = 0;
      repeat (2) begin tick; pulses += int'(done) + int'(err); end
      rst = 1'b1;
      repeat (3) begin tick; pulses += int'(done) + int'(err) + int'(busy); end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL reset_no_pulse: got %0d done/err/busy cycles, want 0", pulses);
      end
      run_xfer(8'h80, 16'h0F0E, 1, 1, -1, dcyc, ecyc, rq, nb, dn, en, oa, od, stable, be);
      checks++;
      if (dcyc !== 5 || oa !== 16'h8180 || od !== 16'h0F0E || en !== 0) begin
         failures++;
         $display("FAIL after_reset_store: got done=%0d addr=%h data=%h err=%0d, want 5 8180 0F0E 0",
                  dcyc, oa, od, en);
      end
   endtask
   initial begin
      bus.mem_ack = 1'b0;
      test_reset;
      test_zero_wait;
      test_wait_capture;
      test_wrap;
      test_timeout;
      test_overlap;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
